pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/redirect controller for the 5-stage core.
- Merges per-stage stall requests into a nested stall vector for the PC and pipeline registers.
- Turns the ID-stage branch decision (branch_flag/branch_addr) into a PC redirect that honours the MIPS delay slot, including when the delay-slot fetch is held up by a slow instruction bus.
- Sits beside the PC register; drives every stage-register stall input and the PC redirect mux.

Parameters:
- ADDR_WIDTH, 32, width of branch/redirect addresses.
- CNT_WIDTH, 32, width of optional performance counters.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- stall_req_if  input  1  instruction bus not ready; delay slot or current fetch not complete.
- stall_req_id  input  1  load-use hazard detected in ID.
- stall_req_ex  input  1  multi-cycle EX operation busy.
- stall_req_mem  input  1  data bus not ready.
- branch_flag  input  1  ID resolves a taken branch/jump this cycle.
- branch_addr  input  ADDR_WIDTH  target for branch_flag.
- stall  output  6  {wb,mem,ex,id,if,pc} hold enables; 1 = hold stage register.
- redirect_valid  output  1  PC loads redirect_addr at next edge.
- redirect_addr  output  ADDR_WIDTH  new PC value; 0 when redirect_valid=0.
- perf_stall_cycles  output  CNT_WIDTH  optional, see below.
- perf_branches  output  CNT_WIDTH  optional, see below.

Behaviour:
- Reset: while rst=0, stall=0, redirect_valid=0, redirect_addr=0, state=IDLE, saved target=0, counters=0. Async assert; deassert takes effect at the next edge.
- Stall vector is combinational, priority mem > ex > id > if:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 0
- The stage immediately after the highest stalled stage receives a bubble. That is the stage-register logic's job (it sees stall[k]=1 and stall[k+1]=0).
- Define id_adv = ~stall[2] and if_adv = ~stall[1].
- FSM states: IDLE, PENDING.
- IDLE:
  - If branch_flag & id_adv & if_adv: the delay slot is captured this cycle. Drive redirect_valid=1 and redirect_addr=branch_addr combinationally (zero added latency). Stay IDLE.
  - If branch_flag & id_adv & ~if_adv: the delay-slot fetch is still outstanding. Latch branch_addr into the saved target and go to PENDING. Drive redirect_valid=0.
  - If branch_flag & ~id_adv: ignore. The branch stays in ID and branch_flag repeats next cycle.
- PENDING:
  - redirect_addr = saved target.
  - redirect_valid = if_adv. The PC advances only when the delay slot is accepted.
  - On if_adv, return to IDLE.
  - branch_flag is ignored in PENDING. A branch in a delay slot is architecturally undefined; the block drops it and does not latch it.
- Reset in PENDING returns to IDLE and clears the saved target; no redirect is issued afterwards.
- redirect_valid never asserts in a cycle where stall[0]=1.
- redirect_addr is passed through unmodified; there is no alignment check.

Optional Feature:
- Macro: PIPELINE_PERF_CNT_EN.
- When defined:
  - perf_stall_cycles increments every cycle with stall!=0.
  - perf_branches increments on each cycle with redirect_valid=1.
  - Both wrap modulo 2^CNT_WIDTH and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Stall priority: stall_req_if=1, stall_req_mem=1 -> stall=6'b011111. Then only stall_req_id=1 -> 6'b000111. All requests 0 -> 6'b000000.
- Same-cycle redirect: IDLE, branch_flag=1, branch_addr=0x0040_0100, no stalls -> redirect_valid=1 and redirect_addr=0x0040_0100 in that cycle. State remains IDLE.
- Pending redirect: branch_flag=1, branch_addr=0xBFC0_0020, stall_req_if=1 for 3 cycles -> redirect_valid=0 for those 3 cycles. In the first cycle with stall_req_if=0, redirect_valid=1 and redirect_addr=0xBFC0_0020. Then back to IDLE.
- ID held by load-use: branch_flag=1 with stall_req_id=1 for 2 cycles, then stall_req_id=0 -> no redirect until the third cycle. redirect_valid pulses exactly once.
- Reset mid-PENDING: enter PENDING with target 0x1234_5678. Pull rst=0 asynchronously mid-cycle -> outputs are 0 immediately. After release with stall_req_if=0, no redirect occurs.
- With PIPELINE_PERF_CNT_EN defined: run 5 stall cycles and 2 redirects -> perf_stall_cycles=5, perf_branches=2. Preload to 2^32-1 and trigger one event -> the counter wraps to 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the stall/redirect controller and the pipeline stages.
// master = pipeline_ctrl, slave = stage registers / PC mux.
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall_req_if;
    logic                  stall_req_id;
    logic                  stall_req_ex;
    logic                  stall_req_mem;
    logic                  branch_flag;
    logic [ADDR_WIDTH-1:0] branch_addr;
    logic [5:0]            stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic [CNT_WIDTH-1:0]  perf_stall_cycles;
    logic [CNT_WIDTH-1:0]  perf_branches;

    modport master (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  branch_flag, branch_addr,
        output stall, redirect_valid, redirect_addr,
        output perf_stall_cycles, perf_branches
    );

    modport slave (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output branch_flag, branch_addr,
        input  stall, redirect_valid, redirect_addr,
        input  perf_stall_cycles, perf_branches
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall vector merge and delay-slot-aware PC redirect for the 5-stage core.
// Optional performance counters are enabled with PIPELINE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  bus
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  w_capture;
    logic [5:0]            w_stall;
    logic                  w_id_adv;
    logic                  w_if_adv;
    logic                  w_redirect_valid;
    logic [ADDR_WIDTH-1:0] w_redirect_addr;

    // Outputs are forced to zero for the whole time reset is held, not just at the edge.
    always_comb begin
        w_stall = 6'b000000;
        if (rst) begin
            if (bus.stall_req_mem)     w_stall = 6'b011111;
            else if (bus.stall_req_ex) w_stall = 6'b001111;
            else if (bus.stall_req_id) w_stall = 6'b000111;
            else if (bus.stall_req_if) w_stall = 6'b000011;
        end
    end

    assign w_id_adv = ~w_stall[2];
    assign w_if_adv = ~w_stall[1];

    always_comb begin
        w_next_state     = r_state;
        w_capture        = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_addr  = '0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (bus.branch_flag && w_id_adv) begin
                        if (w_if_adv) begin
                            w_redirect_valid = 1'b1;
                            w_redirect_addr  = bus.branch_addr;
                        end else begin
                            w_capture    = 1'b1;
                            w_next_state = PENDING;
                        end
                    end
                end
                PENDING: begin
                    // A branch sitting in the delay slot is dropped here.
                    w_redirect_addr  = r_target;
                    w_redirect_valid = w_if_adv;
                    if (w_if_adv) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_target <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) r_target <= bus.branch_addr;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_addr  = w_redirect_addr;

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_perf_stall_cycles;
    logic [CNT_WIDTH-1:0] r_perf_branches;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall_cycles <= '0;
            r_perf_branches     <= '0;
        end else begin
            if (w_stall != 6'b000000) r_perf_stall_cycles <= r_perf_stall_cycles + 1'b1;
            if (w_redirect_valid)     r_perf_branches     <= r_perf_branches + 1'b1;
        end
    end

    assign bus.perf_stall_cycles = r_perf_stall_cycles;
    assign bus.perf_branches     = r_perf_branches;
`else
    assign bus.perf_stall_cycles = {CNT_WIDTH{1'b0}};
    assign bus.perf_branches     = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; covers the perf counters
// when built with PIPELINE_PERF_CNT_EN.
module tb_pipeline_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipeline_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

    pipeline_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic s_if, input logic s_id, input logic s_ex,
                                 input logic s_mem, input logic bf, input logic [31:0] ba);
        @(negedge clk);
        bus.stall_req_if  = s_if;
        bus.stall_req_id  = s_id;
        bus.stall_req_ex  = s_ex;
        bus.stall_req_mem = s_mem;
        bus.branch_flag   = bf;
        bus.branch_addr   = ba;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        checks++;
        if (bus.stall !== 6'b000000) begin
            errors++; $display("[TB] FAIL reset_stall: got %b expected %b", bus.stall, 6'b000000);
        end
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.redirect_valid);
        end
        checks++;
        if (bus.redirect_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_addr: got %h expected 0", bus.redirect_addr);
        end
        checks++;
        if (bus.perf_stall_cycles !== 32'h0 || bus.perf_branches !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_perf: got %h/%h expected 0/0",
                     bus.perf_stall_cycles, bus.perf_branches);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
    endtask

    task automatic test_stall_priority();
        logic [3:0] req [5];
        logic [5:0] exp [5];
        // req = {mem, ex, id, if}
        req[0] = 4'b1001; exp[0] = 6'b011111;
        req[1] = 4'b0010; exp[1] = 6'b000111;
        req[2] = 4'b0111; exp[2] = 6'b001111;
        req[3] = 4'b0001; exp[3] = 6'b000011;
        req[4] = 4'b0000; exp[4] = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(req[i][0], req[i][1], req[i][2], req[i][3], 1'b0, 32'h0);
            checks++;
            if (bus.stall !== exp[i]) begin
                errors++;
                $display("[TB] FAIL stall_prio[%0d]: got %b expected %b", i, bus.stall, exp[i]);
            end
        end
    endtask

    task automatic test_same_cycle_redirect();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h0040_0100) begin
            errors++;
            $display("[TB] FAIL same_cycle: got valid=%b addr=%h expected 1/00400100",
                     bus.redirect_valid, bus.redirect_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL same_cycle_after: got valid=%b addr=%h expected 0/0",
                     bus.redirect_valid, bus.redirect_addr);
        end
    endtask

    task automatic test_pending_redirect();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0020);
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL pending_c0: got valid=%b expected 0", bus.redirect_valid);
        end
        // A second branch during PENDING must be dropped, not latched.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000);
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL pending_c1: got valid=%b expected 0", bus.redirect_valid);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.redirect_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL pending_c2: got valid=%b expected 0", bus.redirect_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'hBFC0_0020) begin
            errors++;
            $display("[TB] FAIL pending_release: got valid=%b addr=%h expected 1/bfc00020",
                     bus.redirect_valid, bus.redirect_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL pending_idle: got valid=%b addr=%h expected 0/0",
                     bus.redirect_valid, bus.redirect_addr);
        end
    endtask

    task automatic test_load_use();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, (i < 2), 1'b0, 1'b0, 1'b1, 32'h0000_2468);
            if (bus.redirect_valid === 1'b1) pulses++;
            checks++;
            if (bus.redirect_valid !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL load_use_c%0d: got valid=%b expected %b",
                         i, bus.redirect_valid, (i == 2));
            end
        end
        checks++;
        if (bus.redirect_addr !== 32'h0000_2468) begin
            errors++; $display("[TB] FAIL load_use_addr: got %h expected 00002468", bus.redirect_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        if (bus.redirect_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            errors++; $display("[TB] FAIL load_use_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_pending();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 6'b000000 || bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pending: got stall=%b valid=%b addr=%h expected 0/0/0",
                     bus.stall, bus.redirect_valid, bus.redirect_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.redirect_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_redirect_c%0d: got valid=%b expected 0",
                         i, bus.redirect_valid);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic test_perf_counters();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PIPELINE_PERF_CNT_EN
        checks++;
        if (bus.perf_stall_cycles !== 32'd5) begin
            errors++; $display("[TB] FAIL perf_stall: got %0d expected 5", bus.perf_stall_cycles);
        end
        checks++;
        if (bus.perf_branches !== 32'd2) begin
            errors++; $display("[TB] FAIL perf_branches: got %0d expected 2", bus.perf_branches);
        end
        force dut.r_perf_stall_cycles = 32'hFFFF_FFFF;
        force dut.r_perf_branches     = 32'hFFFF_FFFF;
        #1;
        release dut.r_perf_stall_cycles;
        release dut.r_perf_branches;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.perf_stall_cycles !== 32'd0) begin
            errors++; $display("[TB] FAIL perf_stall_wrap: got %0d expected 0", bus.perf_stall_cycles);
        end
        checks++;
        if (bus.perf_branches !== 32'd0) begin
            errors++; $display("[TB] FAIL perf_branches_wrap: got %0d expected 0", bus.perf_branches);
        end
`else
        checks++;
        if (bus.perf_stall_cycles !== 32'd0 || bus.perf_branches !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_tied_off: got %0d/%0d expected 0/0",
                     bus.perf_stall_cycles, bus.perf_branches);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.stall_req_if  = 1'b0;
        bus.stall_req_id  = 1'b0;
        bus.stall_req_ex  = 1'b0;
        bus.stall_req_mem = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_addr   = 32'h0;
        test_reset();
        test_stall_priority();
        test_same_cycle_redirect();
        test_pending_redirect();
        test_load_use();
        test_reset_pending();
        test_perf_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
